// File: rtl/rx_edge_bit_timer_pkg.sv
// Shared types and constants for the UART RX oversampling timer.
// Build option: define RX_TRIPLE_SAMPLE_EN for three mid-bit strobes (majority vote).
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam int unsigned MIN_PRESCALE_DEF = 4;

  localparam logic [1:0] SAMPLE_IDX_EARLY = 2'd0;
  localparam logic [1:0] SAMPLE_IDX_MID   = 2'd1;
  localparam logic [1:0] SAMPLE_IDX_LATE  = 2'd2;

endpackage

// File: rtl/rx_edge_bit_timer_sample_decode.sv
// Combinational mid-bit sample strobe decode for the RX timer.
// Build option: RX_TRIPLE_SAMPLE_EN selects strobes at mid-1/mid/mid+1 instead of mid only.
module rx_sample_decode
  import rx_timer_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] edge_count_i,
  input  logic [PRESCALE_W-1:0] p_eff_i,
  input  logic                  active_i,
  output logic                  sample_stb_o,
  output logic [1:0]            sample_idx_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] mid;
  assign mid = p_eff_i >> 1;

`ifdef RX_TRIPLE_SAMPLE_EN
  // A legal prescale keeps mid-1 at or above edge 1, so all three strobes land inside the bit.
  always_comb begin
    sample_stb_o = 1'b0;
    sample_idx_o = SAMPLE_IDX_MID;
    if (active_i) begin
      if (edge_count_i == mid - ONE) begin
        sample_stb_o = 1'b1;
        sample_idx_o = SAMPLE_IDX_EARLY;
      end else if (edge_count_i == mid) begin
        sample_stb_o = 1'b1;
        sample_idx_o = SAMPLE_IDX_MID;
      end else if (edge_count_i == mid + ONE) begin
        sample_stb_o = 1'b1;
        sample_idx_o = SAMPLE_IDX_LATE;
      end
    end
  end
`else
  logic unusedOne;
  assign unusedOne    = ONE[0];
  assign sample_stb_o = active_i && (edge_count_i == mid);
  assign sample_idx_o = SAMPLE_IDX_MID;
`endif

endmodule

// File: rtl/rx_edge_bit_timer.sv
// Oversampling edge/bit timer for the UART receive path with per-frame latched config.
// Build option: RX_TRIPLE_SAMPLE_EN (handled in rx_sample_decode).
module rx_edge_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int PRESCALE_W   = 6,
  parameter int BIT_CNT_W    = 4,
  parameter int MIN_PRESCALE = MIN_PRESCALE_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] EDGE_TWO = PRESCALE_W'(2);
  localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  BIT_TWO  = BIT_CNT_W'(2);

  timer_state_e          state_q;
  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BIT_CNT_W-1:0]  frame_bits_q;
  logic                  cfg_err_q;

  logic                  cfg_ok;
  logic                  active;
  logic [PRESCALE_W-1:0] p_eff;
  logic [BIT_CNT_W-1:0]  f_eff;

  assign cfg_ok = (prescale >= MIN_P) && (frame_bits >= BIT_TWO);

  // The IDLE cycle in which enable rises is edge 1 of bit 1; reset forces all strobes low.
  assign active = RST && ((state_q == RUN) || ((state_q == IDLE) && enable && cfg_ok));
  assign p_eff  = (state_q == RUN) ? prescale_q   : prescale;
  assign f_eff  = (state_q == RUN) ? frame_bits_q : frame_bits;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_q       <= EDGE_ONE;
      bit_q        <= BIT_ONE;
      prescale_q   <= MIN_P;
      frame_bits_q <= BIT_TWO;
      cfg_err_q    <= 1'b0;
    end else begin
      if (!enable) begin
        cfg_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          edge_q <= EDGE_ONE;
          bit_q  <= BIT_ONE;
          if (enable && cfg_ok) begin
            prescale_q   <= prescale;
            frame_bits_q <= frame_bits;
            edge_q       <= EDGE_TWO;
            state_q      <= RUN;
          end else if (enable) begin
            cfg_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
            edge_q  <= EDGE_ONE;
            bit_q   <= BIT_ONE;
          end else if (edge_q == prescale_q) begin
            edge_q <= EDGE_ONE;
            if (bit_q == frame_bits_q) begin
              state_q <= DONE;
              bit_q   <= BIT_ONE;
            end else begin
              bit_q <= bit_q + BIT_ONE;
            end
          end else begin
            edge_q <= edge_q + EDGE_ONE;
          end
        end
        DONE: begin
          edge_q <= EDGE_ONE;
          bit_q  <= BIT_ONE;
          if (!enable) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          edge_q  <= EDGE_ONE;
          bit_q   <= BIT_ONE;
        end
      endcase
    end
  end

  assign edge_count = edge_q;
  assign bit_count  = bit_q;
  assign cfg_err    = cfg_err_q;
  assign bit_done   = active && (edge_q == p_eff);
  assign frame_done = bit_done && (bit_q == f_eff);

  rx_sample_decode #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sample_decode (
    .edge_count_i(edge_q),
    .p_eff_i     (p_eff),
    .active_i    (active),
    .sample_stb_o(sample_stb),
    .sample_idx_o(sample_idx)
  );

endmodule

// File: tb/tb_rx_edge_bit_timer.sv
// Self-checking bench for rx_edge_bit_timer: directed scenarios plus randomized frames
// compared against a frame-timeline model (elapsed cycles -> edge/bit by division).
module tb_rx_edge_bit_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] frame_bits;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fdCyc       = 0;
  int fdCount     = 0;
  int startCyc    = 0;

  // Reference model: a frame is a timeline of elapsed cycles mT with latched mP/mF.
  bit mRun  = 1'b0;
  bit mDone = 1'b0;
  int mT    = 0;
  int mP    = 4;
  int mF    = 2;
  bit mErr  = 1'b0;

  rx_edge_bit_timer dut (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .prescale  (prescale),
    .frame_bits(frame_bits),
    .edge_count(edge_count),
    .bit_count (bit_count),
    .sample_stb(sample_stb),
    .sample_idx(sample_idx),
    .bit_done  (bit_done),
    .frame_done(frame_done),
    .cfg_err   (cfg_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int  e, b, p, f, mid;
    bit  act, bd, fd, stb;
    int  idx;
    cyc++;
    @(negedge CLK);
    if (mRun) begin
      e = mT % mP + 1;
      b = mT / mP + 1;
      p = mP;
      f = mF;
      act = RST;
    end else if (mDone) begin
      e = 1; b = 1; p = int'(prescale); f = int'(frame_bits);
      act = 1'b0;
    end else begin
      e = 1; b = 1; p = int'(prescale); f = int'(frame_bits);
      act = RST && enable && (p >= 4) && (f >= 2);
    end
    bd  = act && (e == p);
    fd  = bd && (b == f);
    mid = p / 2;
`ifdef RX_TRIPLE_SAMPLE_EN
    stb = act && (e >= mid - 1) && (e <= mid + 1);
    idx = e - mid + 1;
`else
    stb = act && (e == mid);
    idx = 1;
`endif
    checkOutput("edge_count", 32'(edge_count), 32'(e));
    checkOutput("bit_count",  32'(bit_count),  32'(b));
    checkOutput("bit_done",   32'(bit_done),   32'(bd));
    checkOutput("frame_done", 32'(frame_done), 32'(fd));
    checkOutput("cfg_err",    32'(cfg_err),    32'(mErr));
    checkOutput("sample_stb", 32'(sample_stb), 32'(stb));
    if (stb) checkOutput("sample_idx", 32'(sample_idx), 32'(idx));
    if (frame_done === 1'b1) begin
      fdCyc = cyc;
      fdCount++;
    end
    @(posedge CLK);
    if (!RST) begin
      mRun = 0; mDone = 0; mT = 0; mP = 4; mF = 2; mErr = 0;
    end else if (mRun) begin
      if (!enable) begin
        mRun = 0;
      end else if (mT == mP * mF - 1) begin
        mRun = 0; mDone = 1;
      end else begin
        mT++;
      end
    end else if (mDone) begin
      if (!enable) mDone = 0;
    end else if (enable && int'(prescale) >= 4 && int'(frame_bits) >= 2) begin
      mRun = 1; mT = 1; mP = int'(prescale); mF = int'(frame_bits);
    end else if (enable) begin
      mErr = 1;
    end
    if (RST && !enable) mErr = 0;
    #1;
  endtask

  task automatic applyStimulus(input logic en, input int pre, input int fb, input logic rst, input int n);
    enable     = en;
    prescale   = pre[5:0];
    frame_bits = fb[3:0];
    RST        = rst;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b0; enable = 1'b0; prescale = 6'd8; frame_bits = 4'd10;
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] reset state");
    applyStimulus(1'($urandom_range(1, 0)), 8, 10, 1'b0, 3);
    applyStimulus(1'b0, 8, 10, 1'b1, 2);

    $display("[TB] full frame prescale=8 frame_bits=10");
    startCyc = cyc; fdCount = 0;
    applyStimulus(1'b1, 8, 10, 1'b1, 85);
    checkOutput("frame_len_8x10", 32'(fdCyc - startCyc), 32'd80);
    checkOutput("frame_done_once", 32'(fdCount), 32'd1);
    applyStimulus(1'b0, 8, 10, 1'b1, 2);

    $display("[TB] enable dropped at bit 5 edge 3");
    fdCount = 0;
    applyStimulus(1'b1, 8, 10, 1'b1, 34);
    applyStimulus(1'b0, 8, 10, 1'b1, 3);
    checkOutput("no_frame_done_on_abort", 32'(fdCount), 32'd0);

    $display("[TB] illegal configurations");
    applyStimulus(1'b1, 3, 10, 1'b1, 4);
    applyStimulus(1'b0, 3, 10, 1'b1, 2);
    applyStimulus(1'b1, 8, 1, 1'b1, 3);
    applyStimulus(1'b0, 8, 1, 1'b1, 2);

    $display("[TB] live prescale change mid-frame");
    startCyc = cyc;
    applyStimulus(1'b1, 8, 10, 1'b1, 20);
    applyStimulus(1'b1, 16, 10, 1'b1, 65);
    checkOutput("frame_len_latched", 32'(fdCyc - startCyc), 32'd80);
    applyStimulus(1'b0, 16, 10, 1'b1, 2);
    startCyc = cyc;
    applyStimulus(1'b1, 16, 10, 1'b1, 165);
    checkOutput("frame_len_16x10", 32'(fdCyc - startCyc), 32'd160);
    applyStimulus(1'b0, 16, 10, 1'b1, 2);

    $display("[TB] reset mid-frame at bit 7");
    applyStimulus(1'b1, 8, 10, 1'b1, 51);
    applyStimulus(1'b1, 8, 10, 1'b0, 1);
    applyStimulus(1'b0, 8, 10, 1'b1, 2);
    startCyc = cyc;
    applyStimulus(1'b1, 8, 10, 1'b1, 82);
    checkOutput("frame_len_after_reset", 32'(fdCyc - startCyc), 32'd80);
    applyStimulus(1'b0, 8, 10, 1'b1, 2);

    $display("[TB] minimum legal frame, enable falls with frame_done");
    startCyc = cyc;
    applyStimulus(1'b1, 4, 2, 1'b1, 7);
    applyStimulus(1'b0, 4, 2, 1'b1, 1);
    checkOutput("frame_len_4x2", 32'(fdCyc - startCyc), 32'd8);
    applyStimulus(1'b0, 4, 2, 1'b1, 1);
    applyStimulus(1'b1, 4, 2, 1'b1, 3);
    applyStimulus(1'b0, 4, 2, 1'b1, 2);

    $display("[TB] randomized frames");
    for (int k = 0; k < 40; k++) begin
      int rp, rf, len;
      rp = int'($urandom_range(12, 4));
      rf = int'($urandom_range(15, 2));
      if ($urandom_range(7, 0) == 0) rp = int'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) rf = int'($urandom_range(1, 0));
      len = int'($urandom_range(rp * rf + 4, 1));
      applyStimulus(1'b1, rp, rf, 1'b1, 1);
      for (int j = 1; j < len; j++) begin
        if ($urandom_range(9, 0) == 0)
          applyStimulus(1'b1, int'($urandom_range(63, 0)), int'($urandom_range(15, 0)),
                        1'($urandom_range(29, 0) != 0), 1);
        else
          applyStimulus(1'b1, rp, rf, 1'b1, 1);
      end
      applyStimulus(1'b0, rp, rf, 1'b1, int'($urandom_range(3, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
